sreg_out_param: RTL and testbench
=================================

// Module: sreg_out_param
// PURPOSE
//  Parametrised serial shift-out engine; successor to the fixed 32-bit UDB shifter.
//  CPU/DMA pushes WIDTH-bit words into an internal FIFO. Each word is shifted out
//  on sdata with a generated sclk, then an optional latch strobe follows (74HC595-style).
//  Adds selectable bit order, back-to-back frames, overflow flag and a done/empty interrupt.
// PARAMETERS
//  WIDTH      32  bits per frame, 2..32
//  DEPTH       4  FIFO words, power of 2, 2..16
//  MSB_FIRST   1  1: shreg[WIDTH-1] first; 0: shreg[0] first
//  LATCH_EN    1  1: one-cycle latch pulse after each frame; 0: no LATCH state
// PORTS
//  clock     in   1      system clock, all logic on rising edge
//  reset_n   in   1      asynchronous reset, active low
//  enable    in   1      1: start frames; 0: finish current frame then idle
//  wr_data   in   WIDTH  word to queue
//  wr_en     in   1      push wr_data when FIFO not full
//  fifo_full out  1      FIFO holds DEPTH words
//  fifo_empty out 1      FIFO holds 0 words
//  ovf       out  1      sticky: write dropped while full; cleared by ovf_clr
//  ovf_clr   in   1      clear ovf (set wins if same cycle)
//  busy      out  1      1 in any state except IDLE
//  isr       out  1      fifo_empty & ~busy (level)
//  sdata     out  1      serial data, registered
//  sclk      out  1      serial clock, registered, idle low
//  latch     out  1      latch strobe, registered, one cycle
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE; sdata=0 sclk=0 latch=0 busy=0 ovf=0;
//   fifo_empty=1 fifo_full=0 isr=1. Reset mid-frame aborts the frame at once, no latch.
//  FIFO: full/empty computed before this cycle's pop; wr_en when full -> word dropped,
//   ovf<=1, even if a pop happens the same cycle. Push+pop on non-full FIFO: count unchanged.
//  States: IDLE, LOAD, SETUP, HOLD, LATCH.
//   IDLE : sclk=0; if enable & ~fifo_empty -> LOAD.
//   LOAD : shreg<=FIFO head, pop, bitcnt<=WIDTH-1 -> SETUP.
//   SETUP: sdata<=first/next bit of shreg, sclk=0 -> HOLD.
//   HOLD : sclk=1 (sdata stable); shift shreg toward out bit;
//          bitcnt==0 -> LATCH if LATCH_EN, else (enable & ~fifo_empty ? LOAD : IDLE);
//          else bitcnt-=1 -> SETUP.
//   LATCH: latch=1 for this cycle only, sclk=0 -> (enable & ~fifo_empty ? LOAD : IDLE).
//  Frame = 1 + 2*WIDTH + LATCH_EN cycles; back-to-back frames have no IDLE gap.
//  Data changes only on SETUP entry (sclk falling or low); receiver samples on sclk rise.
//  sdata holds last bit after frame. bitcnt width $clog2(WIDTH); count width $clog2(DEPTH)+1.
//  enable low mid-frame: frame completes incl. latch, then IDLE; FIFO contents kept.
//  isr rises the cycle after the final HOLD/LATCH when FIFO empty.
// TESTING
//  1 WIDTH=8 MSB_FIRST=1: push 8'hA5 -> sdata 1,0,1,0,0,1,0,1 at 8 sclk rises; latch 1 cycle
//    after 8th rise; frame 18 cycles; isr 0->1 at end.
//  2 WIDTH=8 MSB_FIRST=0: push 8'h01 -> first bit 1, remaining 7 bits 0.
//  3 DEPTH=4: push 5 words while enable=0 -> fifo_full=1 after 4, 5th dropped, ovf=1;
//    ovf_clr -> ovf=0; enable=1 -> exactly 4 frames, no idle cycle between frames.
//  4 Reset_n low at bit 3 of a 32-bit frame -> outputs/flags at reset values immediately,
//    no latch pulse; after release FIFO empty, isr=1.
//  5 enable dropped mid-frame with 2 words queued -> current frame completes with latch,
//    busy=0, fifo_empty=0; re-enable -> next frame starts via LOAD next cycle.
//  6 LATCH_EN=0, WIDTH=16: 2 words -> 33-cycle frames back-to-back, latch never asserted.

Source files
------------

// File: rtl/sreg_out_param.sv
// sreg_out_param - parametrised serial shift-out engine with a word FIFO.
//
// Words pushed on wr_data_i are queued in a DEPTH-entry FIFO. Each word is
// shifted out on sdata_o against a generated sclk_o, optionally followed by a
// one-cycle latch_o strobe for 74HC595-style receivers. Frames run back to back
// while enable_i is high and the FIFO has data.
//
// Ports
//   clock_i       system clock, rising edge
//   reset_n_i     asynchronous reset, active low
//   enable_i      1: start frames; 0: finish current frame then idle
//   wr_data_i     word to queue
//   wr_en_i       push wr_data_i (dropped if FIFO full)
//   ovf_clr_i     clear sticky overflow flag (a same-cycle drop wins)
//   fifo_full_o   FIFO holds DEPTH words
//   fifo_empty_o  FIFO holds no words
//   ovf_o         sticky: a write was dropped while full
//   busy_o        engine is not idle
//   isr_o         fifo_empty_o & ~busy_o
//   sdata_o       serial data, registered
//   sclk_o        serial clock, registered, idle low
//   latch_o       latch strobe, registered, one cycle per frame
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | sclk low, waiting for enable and a queued word
// LOAD    | pop FIFO head into the shift register, reload bit counter
// SETUP   | sdata presents the current bit, sclk low
// HOLD    | sclk high, receiver samples; shift toward the output bit
// LATCH   | one-cycle latch strobe after the last bit (LATCH_EN only)

module sreg_out_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit LATCH_EN  = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_en_i,
    input  logic             ovf_clr_i,
    output logic             fifo_full_o,
    output logic             fifo_empty_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             isr_o,
    output logic             sdata_o,
    output logic             sclk_o,
    output logic             latch_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_HOLD,
        S_LATCH
    } state_t;

    state_t            state_q, state_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;

    logic              sdata_q, sdata_d;
    logic              sclk_q, sclk_d;
    logic              latch_q, latch_d;

    logic              full, empty, push, pop, start;

    // ------------------------------------------------------------------
    // FIFO. Flags come from the registered count, so a full FIFO drops the
    // write even when a pop happens in the same cycle.
    // ------------------------------------------------------------------
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en_i & ~full;
    assign pop   = (state_q == S_LOAD);
    assign start = enable_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_en_i && full) ovf_d = 1'b1;
        else if (ovf_clr_i)  ovf_d = 1'b0;
        else                 ovf_d = ovf_q;
    end

    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sdata_q  <= sdata_d;
            sclk_q   <= sclk_d;
            latch_q  <= latch_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_SETUP;
            S_SETUP: state_d = S_HOLD;
            S_HOLD: begin
                if (bitcnt_q != '0)  state_d = S_SETUP;
                else if (LATCH_EN)   state_d = S_LATCH;
                else if (start)      state_d = S_LOAD;
                else                 state_d = S_IDLE;
            end
            S_LATCH: state_d = start ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shift register and bit counter
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            S_LOAD: begin
                shreg_d  = mem_q[rd_ptr_q];
                bitcnt_d = BW'(WIDTH - 1);
            end
            S_HOLD: begin
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                if (bitcnt_q != '0) bitcnt_d = bitcnt_q - BW'(1);
            end
            default: ;
        endcase
    end

    // FSM: outputs. Computed from the next state so the registered pins line
    // up with the state they belong to; sdata only moves when entering SETUP,
    // which keeps it stable across the sclk rising edge.
    always_comb begin
        sdata_d = sdata_q;
        if (state_d == S_SETUP)
            sdata_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        sclk_d  = (state_d == S_HOLD);
        latch_d = (state_d == S_LATCH);
    end

    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign ovf_o        = ovf_q;
    assign busy_o       = (state_q != S_IDLE);
    assign isr_o        = empty & (state_q == S_IDLE);
    assign sdata_o      = sdata_q;
    assign sclk_o       = sclk_q;
    assign latch_o      = latch_q;

endmodule

// File: tb/tb_sreg_out_param.sv
// Directed bench for sreg_out_param. Four instances share clock, reset,
// enable, ovf_clr and write data; each has its own wr_en:
//   0: WIDTH=8  MSB first, latch     1: WIDTH=8  LSB first, latch
//   2: WIDTH=32 MSB first, latch     3: WIDTH=16 MSB first, no latch

module tb_sreg_out_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ovf_clr;
    logic [31:0] wr_data;
    logic [3:0]  wr_en;
    logic [3:0]  full, empty, ovf, busy, isr, sdata, sclk, latch;

    int n_chk  = 0;
    int n_fail = 0;

    // results of the last run_frames call
    int          r_busy, r_rise, r_latch, r_latgap;
    logic [31:0] r_bits;

    always #5 clk = ~clk;

    sreg_out_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .LATCH_EN(1'b1)) u_m8 (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_data_i(wr_data[7:0]),
        .wr_en_i(wr_en[0]), .ovf_clr_i(ovf_clr), .fifo_full_o(full[0]), .fifo_empty_o(empty[0]),
        .ovf_o(ovf[0]), .busy_o(busy[0]), .isr_o(isr[0]), .sdata_o(sdata[0]), .sclk_o(sclk[0]),
        .latch_o(latch[0]));

    sreg_out_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .LATCH_EN(1'b1)) u_l8 (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_data_i(wr_data[7:0]),
        .wr_en_i(wr_en[1]), .ovf_clr_i(ovf_clr), .fifo_full_o(full[1]), .fifo_empty_o(empty[1]),
        .ovf_o(ovf[1]), .busy_o(busy[1]), .isr_o(isr[1]), .sdata_o(sdata[1]), .sclk_o(sclk[1]),
        .latch_o(latch[1]));

    sreg_out_param #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1), .LATCH_EN(1'b1)) u_m32 (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_data_i(wr_data),
        .wr_en_i(wr_en[2]), .ovf_clr_i(ovf_clr), .fifo_full_o(full[2]), .fifo_empty_o(empty[2]),
        .ovf_o(ovf[2]), .busy_o(busy[2]), .isr_o(isr[2]), .sdata_o(sdata[2]), .sclk_o(sclk[2]),
        .latch_o(latch[2]));

    sreg_out_param #(.WIDTH(16), .DEPTH(4), .MSB_FIRST(1'b1), .LATCH_EN(1'b0)) u_n16 (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .wr_data_i(wr_data[15:0]),
        .wr_en_i(wr_en[3]), .ovf_clr_i(ovf_clr), .fifo_full_o(full[3]), .fifo_empty_o(empty[3]),
        .ovf_o(ovf[3]), .busy_o(busy[3]), .isr_o(isr[3]), .sdata_o(sdata[3]), .sclk_o(sclk[3]),
        .latch_o(latch[3]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int idx, input logic [31:0] data);
        wr_data    = data;
        wr_en[idx] = 1'b1;
        tick();
        wr_en[idx] = 1'b0;
    endtask

    // Observe one instance until busy has been seen and falls again.
    // Captures the bit seen at each sclk rise, busy length and latch pulses.
    task automatic run_frames(input int idx, input int drop_at, input int max_cyc);
        logic seen, done, prev_sclk;
        int   last_rise;
        r_busy = 0; r_rise = 0; r_latch = 0; r_latgap = -1; r_bits = '0;
        seen = 1'b0; done = 1'b0; last_rise = -100;
        prev_sclk = sclk[idx];
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            tick();
            if (cyc == drop_at) enable = 1'b0;
            if (busy[idx]) begin
                seen = 1'b1;
                r_busy++;
            end else if (seen) begin
                done = 1'b1;
            end
            if (sclk[idx] && !prev_sclk) begin
                r_rise++;
                r_bits    = {r_bits[30:0], sdata[idx]};
                last_rise = cyc;
            end
            if (latch[idx]) begin
                r_latch++;
                if (r_latgap < 0) r_latgap = cyc - last_rise;
            end
            prev_sclk = sclk[idx];
        end
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   rises;
        logic ps;
        rst_n = 1'b0; enable = 1'b0; ovf_clr = 1'b0; wr_data = '0; wr_en = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_empty", 32'(empty[0]), 32'd1);
        chk("rst_full",  32'(full[0]),  32'd0);
        chk("rst_isr",   32'(isr[0]),   32'd1);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        chk("rst_outs",  32'({sdata[0], sclk[0], latch[0], ovf[0]}), 32'd0);

        // 1: WIDTH=8 MSB first, 8'hA5
        enable = 1'b1;
        push(0, 32'hA5);
        chk("t1_isr_before", 32'(isr[0]), 32'd0);
        run_frames(0, -1, 60);
        chk("t1_frame_len", r_busy,   32'd18);
        chk("t1_rises",     r_rise,   32'd8);
        chk("t1_bits",      r_bits,   32'hA5);
        chk("t1_latch_cnt", r_latch,  32'd1);
        chk("t1_latch_gap", r_latgap, 32'd1);
        chk("t1_isr_after", 32'(isr[0]), 32'd1);
        chk("t1_sdata_hold", 32'(sdata[0]), 32'd1);
        chk("t1_sclk_idle",  32'(sclk[0]),  32'd0);

        // 2: WIDTH=8 LSB first, 8'h01 -> 1 then seven 0s
        push(1, 32'h01);
        run_frames(1, -1, 60);
        chk("t2_rises", r_rise, 32'd8);
        chk("t2_bits",  r_bits, 32'h80);

        // 3: fill FIFO with enable low, overflow, clear, then drain
        enable = 1'b0;
        push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
        chk("t3_not_full3", 32'(full[0]), 32'd0);
        push(0, 32'h44);
        chk("t3_full4", 32'(full[0]), 32'd1);
        chk("t3_no_ovf", 32'(ovf[0]), 32'd0);
        push(0, 32'h55);
        chk("t3_ovf_set", 32'(ovf[0]), 32'd1);
        chk("t3_still_full", 32'(full[0]), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf[0]), 32'd0);
        wr_data = 32'h66; wr_en[0] = 1'b1; ovf_clr = 1'b1; tick();
        wr_en[0] = 1'b0; ovf_clr = 1'b0;
        chk("t3_set_wins", 32'(ovf[0]), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t3_ovf_clr2", 32'(ovf[0]), 32'd0);
        chk("t3_idle_busy", 32'(busy[0]), 32'd0);
        chk("t3_idle_isr",  32'(isr[0]),  32'd0);
        enable = 1'b1;
        run_frames(0, -1, 200);
        chk("t3_busy_len", r_busy,  32'd72);
        chk("t3_rises",    r_rise,  32'd32);
        chk("t3_bits",     r_bits,  32'h11223344);
        chk("t3_latches",  r_latch, 32'd4);
        chk("t3_empty",    32'(empty[0]), 32'd1);

        // 5: enable dropped mid-frame with two words left behind
        enable = 1'b0;
        push(0, 32'hA1); push(0, 32'hB2); push(0, 32'hC3);
        enable = 1'b1;
        run_frames(0, 6, 100);
        chk("t5_frame_len", r_busy,  32'd18);
        chk("t5_bits",      r_bits,  32'hA1);
        chk("t5_latch",     r_latch, 32'd1);
        chk("t5_busy",      32'(busy[0]),  32'd0);
        chk("t5_not_empty", 32'(empty[0]), 32'd0);
        chk("t5_isr",       32'(isr[0]),   32'd0);
        repeat (3) tick();
        chk("t5_stays_idle", 32'(busy[0]), 32'd0);
        enable = 1'b1;
        tick();
        chk("t5_reenable_load", 32'(busy[0]), 32'd1);
        run_frames(0, -1, 100);
        chk("t5_rest_len",   r_busy,  32'd35);
        chk("t5_rest_bits",  r_bits,  32'hB2C3);
        chk("t5_rest_latch", r_latch, 32'd2);

        // 4: reset in the middle of a 32-bit frame
        push(2, 32'hFFFF_FFFF);
        rises = 0;
        ps    = sclk[2];
        for (int i = 0; i < 40 && rises < 4; i++) begin
            tick();
            if (sclk[2] && !ps) rises++;
            ps = sclk[2];
        end
        chk("t4_reached_bit3", rises, 32'd4);
        chk("t4_mid_state", 32'({busy[2], sclk[2], sdata[2]}), 32'b111);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_outs",  32'({sdata[2], sclk[2], latch[2], busy[2]}), 32'd0);
        chk("t4_rst_flags", 32'({empty[2], full[2], ovf[2], isr[2]}), 32'b1001);
        repeat (2) tick();
        chk("t4_no_latch", 32'(latch[2]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t4_post_empty", 32'(empty[2]), 32'd1);
        chk("t4_post_isr",   32'(isr[2]),   32'd1);
        repeat (3) tick();
        chk("t4_post_idle",  32'(busy[2]),  32'd0);

        // 6: WIDTH=16, no latch state, two frames back to back
        enable = 1'b0;
        push(3, 32'hBEEF); push(3, 32'h1234);
        enable = 1'b1;
        run_frames(3, -1, 200);
        chk("t6_busy_len", r_busy,  32'd66);
        chk("t6_rises",    r_rise,  32'd32);
        chk("t6_bits",     r_bits,  32'hBEEF1234);
        chk("t6_no_latch", r_latch, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
